tff_count_ctrl: RTL and testbench
=================================

TFF_COUNT_CTRL -- requirements
Module: tff_count_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 4, width of the external T flip-flop bank being sequenced.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  begin a count sequence.
REQ-005 SHALL have port: stop  input  1  abort to IDLE.
REQ-006 SHALL have port: pause  input  1  hold count while high.
REQ-007 SHALL have port: mode  input  1  0 = one-shot, 1 = wrap.
REQ-008 SHALL have port: limit  input  WIDTH  terminal count, sampled at start.
REQ-009 SHALL have port: t_en  output  WIDTH  per-bit toggle enables to the T flip-flop bank.
REQ-010 SHALL have port: clr  output  1  bank clear request.
REQ-011 SHALL have port: count  output  WIDTH  mirror of the bank value.
REQ-012 SHALL have port: state  output  2  FSM state.
REQ-013 SHALL have port: busy  output  1  high in RUN or PAUSE.
REQ-014 SHALL have port: done  output  1  one-shot completion pulse.
REQ-015 SHALL have port: wrap  output  1  wrap-mode rollover pulse.

Function
REQ-016 SHALL implement states: IDLE = 00, RUN = 01, PAUSE = 10, DONE = 11.
REQ-017 SHALL treat start as accepted only in IDLE or DONE; on acceptance: limit_q <= limit, mode_q <= mode, count <= 0, state <= RUN.
REQ-018 SHALL drive clr combinationally high during the cycle in which start is accepted, so the bank clears on the same edge.
REQ-019 SHALL drive t_en = 0 in IDLE, PAUSE and DONE, and during the start-acceptance cycle.
REQ-020 SHALL, in RUN with count != limit_q, drive the increment vector: t_en[0] = 1, and t_en[i] = AND of count[i-1:0] for i >= 1.
REQ-021 SHALL update count <= count XOR t_en on every edge in RUN, so that count tracks the bank exactly.
REQ-022 SHALL, in RUN with count == limit_q and mode_q = 0, drive t_en = 0 and set state <= DONE and done <= 1 for exactly one cycle.
REQ-023 SHALL, in RUN with count == limit_q and mode_q = 1, drive t_en = count, so that count returns to 0, keep state RUN, and set wrap <= 1 for one cycle.
REQ-024 SHALL register done and wrap, with each high only in the single cycle after the triggering edge.
REQ-025 SHALL move RUN -> PAUSE when pause = 1, and PAUSE -> RUN when pause = 0.
REQ-026 SHALL hold count unchanged while in PAUSE.
REQ-027 SHALL give pause priority over terminal detection when both apply in the same cycle; the terminal check is re-evaluated after resume.
REQ-028 SHALL, on stop = 1 in any state, set state <= IDLE with t_en = 0 and count retained.
REQ-029 SHALL give stop priority over start and pause.
REQ-030 SHALL ignore start while in RUN or PAUSE.
REQ-031 SHALL, with limit = 0: in one-shot mode, enter DONE on the first RUN edge with no toggles; in wrap mode, assert wrap every RUN cycle with count held at 0.
REQ-032 SHALL allow limit = 2^WIDTH-1, wrapping naturally through all-ones -> 0.
REQ-033 SHALL remain in DONE (busy = 0) until start (restart) or stop (to IDLE) is received.
REQ-034 SHALL require the external bank to be clocked on the same clk edge as this block.

Reset
REQ-035 SHALL, while rst = 0, asynchronously force: state = IDLE, count = 0, limit_q = 0, mode_q = 0, done = 0, wrap = 0.
REQ-036 SHALL, while rst = 0, force t_en = 0, clr = 0 and busy = 0.
REQ-037 SHALL, when reset is asserted mid-RUN, abort the sequence immediately; after release, the block waits in IDLE for start.

Verification
REQ-038 SHALL cover one-shot count: limit = 5, mode = 0, start pulse -> clr = 1 in the accept cycle; count 1, 2, 3, 4, 5 on the next five edges; DONE and done = 1 on the sixth edge; done low one cycle later.
REQ-039 SHALL cover wrap: limit = 3, mode = 1 -> count 0, 1, 2, 3, 0, 1, ...; wrap pulses one cycle after each 3 -> 0 edge; t_en = 0011 at count = 3.
REQ-040 SHALL cover pause: assert pause at count = 2 for 4 cycles -> state PAUSE, t_en = 0, count held at 2; resumes to 3 on the first RUN edge.
REQ-041 SHALL cover stop/start collision: stop and start both high in DONE -> state IDLE, clr = 0, no count change.
REQ-042 SHALL cover async reset: rst low mid-count (count = 4, WIDTH = 4, limit = 15) -> outputs zero without waiting for a clock edge; a start after release restarts the count from 0.
REQ-043 SHALL cover boundaries: limit = 0, mode = 0 -> DONE on the first edge after acceptance, t_en never nonzero; limit = 15, mode = 1 -> t_en = 1111 at count = 15 and count returns to 0.

Source files
------------

// File: rtl/tff_count_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tff_count_ctrl
//  Description : Sequencer for an external bank of WIDTH T flip-flops.
//                Produces per-bit toggle enables so the bank counts from 0
//                up to a sampled limit. In one-shot mode it stops in DONE.
//                In wrap mode it rolls back to 0 and keeps running.
//                Also provides pause, stop and a mirrored copy of the count.
//  Revision    : 1.0  initial release
// ============================================================================
module tff_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] t_en,
    output logic             clr,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    localparam logic [1:0] c_IDLE  = 2'b00;
    localparam logic [1:0] c_RUN   = 2'b01;
    localparam logic [1:0] c_PAUSE = 2'b10;
    localparam logic [1:0] c_DONE  = 2'b11;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_limit;
    logic             r_mode;
    logic             r_done;
    logic             r_wrap;

    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_t_en;
    logic             w_start_acc;
    logic             w_run_active;
    logic             w_term;

    // Bit 0 always toggles on an increment.
    assign w_inc[0] = 1'b1;

    // Bit i toggles when all lower bits are ones (ripple-carry of +1).
    generate
        for (genvar i = 1; i < WIDTH; i++) begin : g_inc_bit
            assign w_inc[i] = &r_count[i-1:0];
        end
    endgenerate

    // Decode start acceptance, the active-count condition and the toggle vector.
    always_comb begin
        w_start_acc  = rst && start && !stop &&
                       ((r_state == c_IDLE) || (r_state == c_DONE));
        w_run_active = rst && (r_state == c_RUN) && !stop && !pause;
        w_term       = (r_count == r_limit);
        w_t_en       = '0;
        if (w_run_active) begin
            if (!w_term) begin
                w_t_en = w_inc;
            end else if (r_mode) begin
                // Toggling every set bit clears the bank back to zero.
                w_t_en = r_count;
            end
        end
    end

    // State, count mirror, sampled configuration and the registered pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_count <= '0;
            r_limit <= '0;
            r_mode  <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            if (stop) begin
                // Abort to IDLE. The count is retained.
                r_state <= c_IDLE;
            end else begin
                case (r_state)
                    c_IDLE, c_DONE: begin
                        if (w_start_acc) begin
                            r_limit <= limit;
                            r_mode  <= mode;
                            r_count <= '0;
                            r_state <= c_RUN;
                        end
                    end
                    c_RUN: begin
                        if (pause) begin
                            // Pause takes precedence; terminal check happens after resume.
                            r_state <= c_PAUSE;
                        end else begin
                            r_count <= r_count ^ w_t_en;
                            if (w_term) begin
                                if (r_mode) begin
                                    r_wrap <= 1'b1;
                                end else begin
                                    r_state <= c_DONE;
                                    r_done  <= 1'b1;
                                end
                            end
                        end
                    end
                    c_PAUSE: begin
                        if (!pause) begin
                            r_state <= c_RUN;
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

    assign t_en  = w_t_en;
    assign clr   = w_start_acc;
    assign count = r_count;
    assign state = r_state;
    assign busy  = rst && ((r_state == c_RUN) || (r_state == c_PAUSE));
    assign done  = r_done;
    assign wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_tff_count_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tff_count_ctrl
//  Description : Directed self-checking bench for tff_count_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tff_count_ctrl;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             pause;
    logic             mode;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] t_en;
    logic             clr;
    logic [WIDTH-1:0] count;
    logic [1:0]       state;
    logic             busy;
    logic             done;
    logic             wrap;

    int n_vec = 0;
    int n_err = 0;

    tff_count_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .pause (pause),
        .mode  (mode),
        .limit (limit),
        .t_en  (t_en),
        .clr   (clr),
        .count (count),
        .state (state),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int e;
        int n;
        rst   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        mode  = 1'b0;
        limit = '0;

        // Reset state, including clr suppressed while reset is held.
        #3;
        check_val("rst_state", int'(state), 0);
        check_val("rst_count", int'(count), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_wrap", int'(wrap), 0);
        start = 1'b1;
        #1;
        check_val("rst_clr", int'(clr), 0);
        check_val("rst_t_en", int'(t_en), 0);
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();

        // One-shot, limit 5.
        limit = 4'd5; mode = 1'b0; start = 1'b1;
        #1;
        check_val("os_clr_accept", int'(clr), 1);
        check_val("os_t_en_accept", int'(t_en), 0);
        step();
        start = 1'b0;
        #1;
        check_val("os_state_run", int'(state), 1);
        check_val("os_count0", int'(count), 0);
        check_val("os_busy", int'(busy), 1);
        check_val("os_clr_low", int'(clr), 0);
        for (int i = 0; i < 5; i++) begin
            check_val("os_t_en", int'(t_en), i ^ (i + 1));
            step();
            check_val("os_count", int'(count), i + 1);
            check_val("os_done_low", int'(done), 0);
        end
        check_val("os_t_en_term", int'(t_en), 0);
        step();
        check_val("os_state_done", int'(state), 3);
        check_val("os_done_pulse", int'(done), 1);
        check_val("os_busy_done", int'(busy), 0);
        check_val("os_count_held", int'(count), 5);
        step();
        check_val("os_done_clear", int'(done), 0);
        check_val("os_state_stay", int'(state), 3);

        // Stop and start together in DONE: stop wins.
        stop = 1'b1; start = 1'b1;
        #1;
        check_val("col_clr", int'(clr), 0);
        step();
        stop = 1'b0; start = 1'b0;
        check_val("col_state", int'(state), 0);
        check_val("col_count", int'(count), 5);

        // Wrap mode, limit 3.
        limit = 4'd3; mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check_val("wr_count0", int'(count), 0);
        e = 0;
        for (int k = 0; k < 9; k++) begin
            if (k == 4) begin
                start = 1'b1;
                #1;
                check_val("wr_start_ignored_clr", int'(clr), 0);
            end
            #1;
            check_val("wr_t_en", int'(t_en), (e == 3) ? 3 : (e ^ (e + 1)));
            step();
            start = 1'b0;
            check_val("wr_wrap", int'(wrap), (e == 3) ? 1 : 0);
            e = (e == 3) ? 0 : e + 1;
            check_val("wr_count", int'(count), e);
            check_val("wr_state", int'(state), 1);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_val("wr_stop_state", int'(state), 0);

        // Pause at count 2 for four cycles.
        limit = 4'd5; mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check_val("pz_count_pre", int'(count), 2);
        pause = 1'b1;
        #1;
        check_val("pz_t_en_zero", int'(t_en), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_val("pz_state", int'(state), 2);
            check_val("pz_count", int'(count), 2);
            check_val("pz_t_en", int'(t_en), 0);
            check_val("pz_busy", int'(busy), 1);
        end
        pause = 1'b0;
        step();
        check_val("pz_resume_state", int'(state), 1);
        check_val("pz_resume_count", int'(count), 2);
        step();
        check_val("pz_count3", int'(count), 3);
        step();
        step();
        check_val("pz_count5", int'(count), 5);
        // Pause coincides with terminal count: pause wins.
        pause = 1'b1;
        step();
        check_val("pzt_state", int'(state), 2);
        check_val("pzt_done", int'(done), 0);
        pause = 1'b0;
        step();
        check_val("pzt_resume", int'(state), 1);
        step();
        check_val("pzt_state_done", int'(state), 3);
        check_val("pzt_done_pulse", int'(done), 1);

        // limit 0, one-shot, restarted straight from DONE.
        limit = 4'd0; mode = 1'b0; start = 1'b1;
        #1;
        check_val("l0_clr", int'(clr), 1);
        step();
        start = 1'b0;
        #1;
        check_val("l0_t_en", int'(t_en), 0);
        step();
        check_val("l0_state_done", int'(state), 3);
        check_val("l0_done", int'(done), 1);
        check_val("l0_count", int'(count), 0);

        // limit 0, wrap mode: wrap every cycle, count stays 0.
        limit = 4'd0; mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val("l0w_t_en", int'(t_en), 0);
            step();
            check_val("l0w_wrap", int'(wrap), 1);
            check_val("l0w_count", int'(count), 0);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;

        // limit 15, wrap: full rollover through all-ones.
        limit = 4'd15; mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (n < 15) begin
            step();
            n++;
        end
        check_val("l15_count", int'(count), 15);
        check_val("l15_t_en", int'(t_en), 15);
        step();
        check_val("l15_count_rollover", int'(count), 0);
        check_val("l15_wrap", int'(wrap), 1);

        // Asynchronous reset with count 4.
        step(); step(); step(); step();
        check_val("ar_count_pre", int'(count), 4);
        rst = 1'b0;
        #1;
        check_val("ar_count", int'(count), 0);
        check_val("ar_state", int'(state), 0);
        check_val("ar_busy", int'(busy), 0);
        check_val("ar_t_en", int'(t_en), 0);
        step();
        rst = 1'b1;
        step();
        check_val("ar_idle_wait", int'(state), 0);
        limit = 4'd15; mode = 1'b0; start = 1'b1;
        #1;
        check_val("ar_restart_clr", int'(clr), 1);
        step();
        start = 1'b0;
        check_val("ar_restart_count0", int'(count), 0);
        step();
        check_val("ar_restart_count1", int'(count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
